// File: rtl/iris_argmax_classifier.sv
// Argmax stage of the Iris network: captures three signed class scores and resolves
// the winner, its margin over the runner-up and a confidence flag over five edges.
module iris_argmax_classifier #(
   parameter  int DATA_WIDTH = 8,
   parameter  int MIN_MARGIN = 0,
   localparam int SW         = DATA_WIDTH + 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 En,
   input  logic                 Run,
   input  logic signed [SW-1:0] Y0,
   input  logic signed [SW-1:0] Y1,
   input  logic signed [SW-1:0] Y2,
   output logic                 Busy,
   output logic                 Valid,
   output logic [1:0]           Class,
   output logic signed [SW-1:0] MaxScore,
   output logic [SW-1:0]        Margin,
   output logic                 Confident
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CMP1   = 3'd1,
      CMP2   = 3'd2,
      MARGIN = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam logic signed [SW-1:0] MIN_SCORE = {1'b1, {(SW-1){1'b0}}};
   localparam logic [SW-1:0]        MIN_M     = MIN_MARGIN[SW-1:0];

   state_t                state;
   state_t                state_next;
   logic signed [SW-1:0]  s1;
   logic signed [SW-1:0]  s2;
   logic signed [SW-1:0]  best;
   logic signed [SW-1:0]  second;
   logic [1:0]            idx;
   logic [SW-1:0]         mreg;
   logic signed [SW-1:0]  cmp_val;
   logic [1:0]            cmp_idx;
   logic                  start;

   // A Run seen in the Valid cycle belongs to the finished operation, so it is dropped.
   assign start = (state == IDLE) && Run && !Valid;
   assign Busy  = (state != IDLE);

   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      state_next = state;
      unique case (state)
         IDLE:    if (start) state_next = CMP1;
         CMP1:    state_next = CMP2;
         CMP2:    state_next = MARGIN;
         MARGIN:  state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      cmp_val = s1;
      cmp_idx = 2'd1;
      if (state == CMP2) begin
         cmp_val = s2;
         cmp_idx = 2'd2;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else if (En) begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1        <= '0;
         s2        <= '0;
         best      <= '0;
         second    <= '0;
         idx       <= '0;
         mreg      <= '0;
         Class     <= '0;
         MaxScore  <= '0;
         Margin    <= '0;
         Confident <= 1'b0;
         Valid     <= 1'b0;
      end else if (En) begin
         Valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  s1     <= Y1;
                  s2     <= Y2;
                  best   <= Y0;
                  idx    <= 2'd0;
                  second <= MIN_SCORE;
               end
            end
            CMP1, CMP2: begin
               // Strict compares keep the lowest index on ties and let a tie land in second.
               if (cmp_val > best) begin
                  second <= best;
                  best   <= cmp_val;
                  idx    <= cmp_idx;
               end else if (cmp_val > second) begin
                  second <= cmp_val;
               end
            end
            MARGIN: begin
               // best >= second, so the true difference fits SW unsigned bits and the
               // modulo-2^SW result equals the SW+1-bit difference exactly.
               mreg <= best - second;
            end
            DONE: begin
               Class     <= idx;
               MaxScore  <= best;
               Margin    <= mreg;
               Confident <= (mreg > MIN_M);
               Valid     <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
